// File: rtl/io_sw_debounce_pkg.sv
// Shared board constants and helpers for the Io-board switch debouncer.
// STABLE_CYCLES defaults are derived from the board clock and debounce window.
package io_sw_debounce_pkg;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  function automatic int unsigned cycles_for_ms(input int unsigned clk_hz,
                                                input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int unsigned STABLE_CYCLES_DEFAULT = cycles_for_ms(CLK_HZ, DEBOUNCE_MS);

  // Counter only needs to reach STABLE_CYCLES-1, so $clog2 is always wide enough.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/io_sw_debounce_ch.sv
// One switch channel: two-flop synchroniser, stability counter, level and
// single-cycle rise/fall pulses.
module debounce_ch
  import io_sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign s = sync_q[1] ^ ACTIVE_LOW;

  // Any sample matching the current level restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = s;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sw_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign rise_next = rise_d;

endmodule

// File: rtl/io_sw_debounce.sv
// Debounces N_SW raw switch pins into clean levels, edge pulses, per-channel
// toggle state and a combined any-rise event.
module io_sw_debounce
  import io_sw_debounce_pkg::*;
#(
  parameter int unsigned N_SW          = 5,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_level,
  output logic [N_SW-1:0] o_rise,
  output logic [N_SW-1:0] o_fall,
  output logic [N_SW-1:0] o_toggle,
  output logic            o_any_rise
);

  logic [N_SW-1:0] level, rise, fall, rise_next;
  logic [N_SW-1:0] toggle_q, toggle_d;
  logic            any_rise_q, any_rise_d;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sw_raw    (i_sw[g]),
      .level     (level[g]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .rise_next (rise_next[g])
    );
  end

  // any_rise is built from next-state pulses so it lands with o_rise.
  always_comb begin
    toggle_d   = toggle_q ^ rise;
    any_rise_d = |rise_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q   <= '0;
      any_rise_q <= 1'b0;
    end else begin
      toggle_q   <= toggle_d;
      any_rise_q <= any_rise_d;
    end
  end

  assign o_level    = level;
  assign o_rise     = rise;
  assign o_fall     = fall;
  assign o_toggle   = toggle_q;
  assign o_any_rise = any_rise_q;

endmodule

// File: tb/tb_io_sw_debounce.sv
// Scoreboard bench for io_sw_debounce: a run-length reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_io_sw_debounce;

  localparam int unsigned N  = 5;
  localparam int unsigned ST = 4;
  localparam bit          AL = 1'b0;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_sw;
  logic [N-1:0] o_level, o_rise, o_fall, o_toggle;
  logic         o_any_rise;

  int checks = 0;
  int errors = 0;

  io_sw_debounce #(
    .N_SW          (N),
    .STABLE_CYCLES (ST),
    .ACTIVE_LOW    (AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sw       (i_sw),
    .o_level    (o_level),
    .o_rise     (o_rise),
    .o_fall     (o_fall),
    .o_toggle   (o_toggle),
    .o_any_rise (o_any_rise)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] toggle;
    logic         any;
  } obs_t;

  obs_t exp_q[$];

  // Reference model: pins reach the decision point two edges late; a level is
  // accepted once ST consecutive samples disagree with it.
  logic [N-1:0] pin_hist1, pin_hist2, m_level, m_rise, m_toggle;
  int           m_run[N];

  always @(posedge clk) begin : model
    obs_t         e;
    logic [N-1:0] s, nl, nr, nf;
    if (rst) begin
      pin_hist1 = '0;
      pin_hist2 = '0;
      m_level   = '0;
      m_rise    = '0;
      m_toggle  = '0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
      e = '0;
    end else begin
      s  = pin_hist2 ^ {N{AL}};
      nl = m_level;
      nr = '0;
      nf = '0;
      for (int c = 0; c < N; c++) begin
        if (s[c] == m_level[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == ST) begin
            nl[c]    = s[c];
            nr[c]    = s[c];
            nf[c]    = ~s[c];
            m_run[c] = 0;
          end
        end
      end
      m_toggle  = m_toggle ^ m_rise;
      m_level   = nl;
      m_rise    = nr;
      pin_hist2 = pin_hist1;
      pin_hist1 = i_sw;
      e.level  = nl;
      e.rise   = nr;
      e.fall   = nf;
      e.toggle = m_toggle;
      e.any    = |nr;
    end
    exp_q.push_back(e);
  end

  int rise_cnt[N];
  int fall_cnt[N];
  bit saw_simul = 1'b0;
  int cyc_no    = 0;

  always @(negedge clk) begin : monitor
    obs_t e, a;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_level, o_rise, o_fall, o_toggle, o_any_rise};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got lvl=%b rise=%b fall=%b tog=%b any=%b exp lvl=%b rise=%b fall=%b tog=%b any=%b",
                 cyc_no, a.level, a.rise, a.fall, a.toggle, a.any,
                 e.level, e.rise, e.fall, e.toggle, e.any);
      end
      for (int c = 0; c < N; c++) begin
        if (o_rise[c]) rise_cnt[c]++;
        if (o_fall[c]) fall_cnt[c]++;
      end
      if (o_rise == 5'b11000 && o_any_rise) saw_simul = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    logic [4:0] bounce;
    int         r0, f0;
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] = 0;
      fall_cnt[c] = 0;
    end
    rst  = 1'b1;
    i_sw = 5'b11111;
    cyc(3);
    rst  = 1'b0;
    i_sw = '0;
    cyc(10);

    // Clean press on ch0
    i_sw[0] = 1'b1;
    cyc(12);
    check("press_rise_cnt0", rise_cnt[0], 1);
    check("press_toggle0", int'(o_toggle[0]), 1);
    check("press_level0", int'(o_level[0]), 1);

    // Bounce train on ch1 must be rejected
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      i_sw[1] = bounce[i];
      cyc(1);
    end
    i_sw[1] = 1'b0;
    cyc(12);
    check("bounce_rise_cnt1", rise_cnt[1], 0);
    check("bounce_level1", int'(o_level[1]), 0);

    // Bounce then settle on ch2
    i_sw[2] = 1'b1; cyc(1);
    i_sw[2] = 1'b0; cyc(1);
    i_sw[2] = 1'b1;
    cyc(12);
    check("settle_rise_cnt2", rise_cnt[2], 1);

    // Release and second press on ch0
    i_sw[0] = 1'b0;
    cyc(12);
    check("release_fall_cnt0", fall_cnt[0], 1);
    i_sw[0] = 1'b1;
    cyc(12);
    check("second_rise_cnt0", rise_cnt[0], 2);
    check("second_toggle0", int'(o_toggle[0]), 0);

    // Simultaneous rise on ch3/ch4
    i_sw[4:3] = 2'b11;
    cyc(12);
    check("simul_seen", int'(saw_simul), 1);

    // Reset two cycles into a pending release on ch0
    r0 = rise_cnt[0];
    f0 = fall_cnt[0];
    i_sw[0] = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(12);
    check("rst_mid_fall0", fall_cnt[0], f0);
    check("rst_mid_rise0", rise_cnt[0], r0);

    // Randomised bounce with occasional quiet stretches and resets
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) < 180) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(5) == 0) i_sw[c] = ~i_sw[c];
      end
      rst = ($urandom_range(499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
